// File: rtl/cpu_restart_sequencer_pkg.sv
// Shared definitions for the CPU restart sequencer: state encoding,
// default timing constants and small state-classification helpers.
package cpu_restart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OFF     = 3'd1,
    ST_BOOT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DEAD    = 3'd5
  } seq_state_e;

  localparam int DEF_OFF_CYCLES   = 1000;
  localparam int DEF_BOOT_CYCLES  = 50000;
  localparam int DEF_CHECK_CYCLES = 10000;
  localparam int DEF_HB_EDGES     = 4;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CNT_W        = 32;

  // States in which the granted board is held under power override.
  function automatic logic is_overridden(seq_state_e s);
    return (s == ST_OFF) || (s == ST_BOOT) || (s == ST_CHECK);
  endfunction

  // States in which the granted board is commanded on.
  function automatic logic is_powered(seq_state_e s);
    return (s == ST_BOOT) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/cpu_restart_sequencer_hb_edge_detect.sv
// Heartbeat conditioning: 2-flop synchronizer followed by a third flop
// so a rising edge becomes a single-cycle pulse in the clk domain.
module hb_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic hb_async,
  output logic hb_rise
);

  // sync_q[0..1] form the synchronizer, sync_q[2] is the edge history.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw heartbeat through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[1:0], hb_async};
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= sync_d;
  end

  assign hb_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cpu_restart_sequencer.sv
// Restart sequencer for two CPU boards sharing one power rail: power-off
// hold, power-on, boot grace, heartbeat check, bounded retries, with
// round-robin arbitration so only one board power-cycles at a time.
// Optional macro RESTART_IRQ_EN: when defined, irq pulses for one cycle
// on entry to RELEASE or DEAD; otherwise irq is tied low.
module cpu_restart_sequencer
  import cpu_restart_sequencer_pkg::*;
#(
  parameter int OFF_CYCLES   = DEF_OFF_CYCLES,
  parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES,
  parameter int CHECK_CYCLES = DEF_CHECK_CYCLES,
  parameter int HB_EDGES     = DEF_HB_EDGES,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cpu_fail_a,
  input  logic       cpu_fail_b,
  input  logic       heartbeat_a,
  input  logic       heartbeat_b,
  output logic       force_power_control_a,
  output logic       force_power_control_b,
  output logic       cmd_power_on_a,
  output logic       cmd_power_on_b,
  output logic       busy,
  output logic       grant_b,
  output logic [1:0] retry_cnt,
  output logic       dead_a,
  output logic       dead_b,
  output logic       irq
);

  localparam int EDGE_W = $clog2(HB_EDGES + 1);
  localparam logic [CNT_W-1:0]  OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CHECK_LAST = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(HB_EDGES - 1);
  localparam logic [1:0]        RETRY_LAST = 2'(MAX_RETRY - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              grant_b_q, grant_b_d;
  logic              rr_q, rr_d;
  logic              rel_block_q, rel_block_d;
  logic [1:0]        retry_q, retry_d;
  logic              dead_a_q, dead_a_d, dead_b_q, dead_b_d;
  logic              busy_q, busy_d;
  logic              force_a_q, force_a_d, force_b_q, force_b_d;
  logic              cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;

  logic hb_rise_a, hb_rise_b, hb_rise_sel;
  logic req_a, req_b;

  hb_edge_detect u_hb_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .hb_async (heartbeat_a),
    .hb_rise  (hb_rise_a)
  );

  hb_edge_detect u_hb_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .hb_async (heartbeat_b),
    .hb_rise  (hb_rise_b)
  );

  // Next-state, counter and registered-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 1'b1;
    edge_d      = edge_q;
    grant_b_d   = grant_b_q;
    rr_d        = rr_q;
    rel_block_d = 1'b0;
    retry_d     = retry_q;
    dead_a_d    = dead_a_q;
    dead_b_d    = dead_b_q;

    hb_rise_sel = grant_b_q ? hb_rise_b : hb_rise_a;
    // The side just released sits out the first idle cycle.
    req_a = cpu_fail_a & ~dead_a_q & enable & ~(rel_block_q & ~grant_b_q);
    req_b = cpu_fail_b & ~dead_b_q & enable & ~(rel_block_q &  grant_b_q);

    if (!enable && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      retry_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_a && req_b) begin
            grant_b_d = rr_q;
            rr_d      = ~rr_q;
            state_d   = ST_OFF;
          end else if (req_a) begin
            grant_b_d = 1'b0;
            state_d   = ST_OFF;
          end else if (req_b) begin
            grant_b_d = 1'b1;
            state_d   = ST_OFF;
          end
        end
        ST_OFF: begin
          if (phase_q == OFF_LAST) state_d = ST_BOOT;
        end
        ST_BOOT: begin
          if (phase_q == BOOT_LAST) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          // A completed heartbeat count wins over a window expiring together.
          if (hb_rise_sel && (edge_q == EDGE_LAST)) begin
            state_d = ST_RELEASE;
            retry_d = 2'd0;
          end else if (phase_q == CHECK_LAST) begin
            if (retry_q == RETRY_LAST) begin
              state_d = ST_DEAD;
              if (grant_b_q) dead_b_d = 1'b1;
              else           dead_a_d = 1'b1;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_OFF;
            end
          end else begin
            edge_d = edge_q + EDGE_W'(hb_rise_sel);
          end
        end
        ST_RELEASE: begin
          state_d     = ST_IDLE;
          rel_block_d = 1'b1;
        end
        ST_DEAD: begin
          state_d = ST_IDLE;
          retry_d = 2'd0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if ((state_d != state_q) || (state_d == ST_IDLE)) begin
      phase_d = '0;
      edge_d  = '0;
    end

    // A dead board is held unpowered regardless of the sequence.
    busy_d    = (state_d != ST_IDLE);
    force_a_d = dead_a_d | (~grant_b_d & is_overridden(state_d));
    force_b_d = dead_b_d | ( grant_b_d & is_overridden(state_d));
    cmd_a_d   = ~dead_a_d & ~grant_b_d & is_powered(state_d);
    cmd_b_d   = ~dead_b_d &  grant_b_d & is_powered(state_d);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      edge_q      <= '0;
      grant_b_q   <= 1'b0;
      rr_q        <= 1'b0;
      rel_block_q <= 1'b0;
      retry_q     <= 2'd0;
      dead_a_q    <= 1'b0;
      dead_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      force_a_q   <= 1'b0;
      force_b_q   <= 1'b0;
      cmd_a_q     <= 1'b0;
      cmd_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      edge_q      <= edge_d;
      grant_b_q   <= grant_b_d;
      rr_q        <= rr_d;
      rel_block_q <= rel_block_d;
      retry_q     <= retry_d;
      dead_a_q    <= dead_a_d;
      dead_b_q    <= dead_b_d;
      busy_q      <= busy_d;
      force_a_q   <= force_a_d;
      force_b_q   <= force_b_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
    end
  end

  assign force_power_control_a = force_a_q;
  assign force_power_control_b = force_b_q;
  assign cmd_power_on_a        = cmd_a_q;
  assign cmd_power_on_b        = cmd_b_q;
  assign busy                  = busy_q;
  assign grant_b               = grant_b_q;
  assign retry_cnt             = retry_q;
  assign dead_a                = dead_a_q;
  assign dead_b                = dead_b_q;

`ifdef RESTART_IRQ_EN
  logic irq_q, irq_d;

  // RELEASE and DEAD never self-loop, so being next-state marks entry.
  always_comb begin
    irq_d = (state_d == ST_RELEASE) || (state_d == ST_DEAD);
  end

  // Completion interrupt pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
